// File: rtl/bus_arbiter_if.sv
// Bus bundle between the 65C02 core, the debug/loader port and the shared RIOT/ROM bus.
// The arbiter takes the slave view; whoever drives the core, debug and memory sides takes the master view.
interface bus_arbiter_if;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;

    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_halt;
    logic        dbg_ack;
    logic [7:0]  dbg_rdata;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        rom_cs;
    logic        riot_ram_cs;
    logic        riot_io_cs;
    logic [7:0]  rom_rdata;
    logic [7:0]  riot_rdata;

    modport slave (
        input  cpu_ab, cpu_do, cpu_we,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  rom_rdata, riot_rdata,
        output cpu_di, cpu_rdy, dbg_ack, dbg_rdata,
        output mem_addr, mem_wdata, mem_we, rom_cs, riot_ram_cs, riot_io_cs
    );

    modport master (
        output cpu_ab, cpu_do, cpu_we,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output rom_rdata, riot_rdata,
        input  cpu_di, cpu_rdy, dbg_ack, dbg_rdata,
        input  mem_addr, mem_wdata, mem_we, rom_cs, riot_ram_cs, riot_io_cs
    );
endinterface

// File: rtl/bus_arbiter.sv
// Shares the RIOT/ROM bus between the 65C02 core and the debug/loader port.
// The core is stalled through RDY whenever the debug side owns the bus or holds a halt.
module bus_arbiter #(
    parameter logic [3:0]  ROM_BASE = 4'hF,
    parameter logic [8:0]  RAM_BASE = 9'h001,
    parameter logic [10:0] IO_BASE  = 11'h014
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_DBG  = 2'd1,
        ST_ACK  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_ROM   = 2'd1,
        SEL_RIOT  = 2'd2,
        SEL_UNMAP = 2'd3
    } rsel_e;

    function automatic logic hit_rom(input logic [15:0] addr);
        hit_rom = (addr[15:12] == ROM_BASE);
    endfunction

    function automatic logic hit_ram(input logic [15:0] addr);
        hit_ram = (addr[15:7] == RAM_BASE);
    endfunction

    function automatic logic hit_io(input logic [15:0] addr);
        hit_io = (addr[15:5] == IO_BASE);
    endfunction

    state_e      state_q, state_d;
    rsel_e       rsel_q, rsel_d;
    logic        owner_cpu_q, owner_cpu_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  dbg_rdata_q, dbg_rdata_d;

    logic        bus_active_s;
    logic [15:0] src_addr_s;
    logic [7:0]  src_wdata_s;
    logic        src_we_s;
    logic        rom_cs_s;
    logic        ram_cs_s;
    logic        io_cs_s;
    logic [7:0]  rd_mux_s;

    // State register and read-return registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_CPU;
            rsel_q      <= SEL_NONE;
            owner_cpu_q <= 1'b0;
            hold_q      <= 8'h00;
            dbg_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rsel_q      <= rsel_d;
            owner_cpu_q <= owner_cpu_d;
            hold_q      <= hold_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Next-state logic; a pending request always beats a halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CPU: begin
                if (bus.dbg_req) begin
                    state_d = ST_DBG;
                end else if (bus.dbg_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_CPU;
                end
            end
            ST_DBG: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (bus.dbg_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_CPU;
                end
            end
            ST_HALT: begin
                if (bus.dbg_req) begin
                    state_d = ST_DBG;
                end else if (!bus.dbg_halt) begin
                    state_d = ST_CPU;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase
    end

    // Bus source select; idle states park the address on the CPU bus with no strobe.
    always_comb begin
        bus_active_s = 1'b0;
        src_addr_s   = bus.cpu_ab;
        src_wdata_s  = bus.cpu_do;
        src_we_s     = 1'b0;
        case (state_q)
            ST_CPU: begin
                bus_active_s = 1'b1;
                src_we_s     = bus.cpu_we;
            end
            ST_DBG: begin
                bus_active_s = 1'b1;
                src_addr_s   = bus.dbg_addr;
                src_wdata_s  = bus.dbg_wdata;
                src_we_s     = bus.dbg_we;
            end
            default: begin
                bus_active_s = 1'b0;
            end
        endcase
    end

    // Chip-select decode; priority order keeps the selects one-hot even with overlapping bases.
    always_comb begin
        rom_cs_s = 1'b0;
        ram_cs_s = 1'b0;
        io_cs_s  = 1'b0;
        if (bus_active_s && reset_n) begin
            rom_cs_s = hit_rom(src_addr_s);
            ram_cs_s = hit_ram(src_addr_s) && !hit_rom(src_addr_s);
            io_cs_s  = hit_io(src_addr_s) && !hit_rom(src_addr_s) && !hit_ram(src_addr_s);
        end else begin
            rom_cs_s = 1'b0;
        end
    end

    // Remember where this cycle's read data will come from and who asked for it.
    always_comb begin
        rsel_d      = SEL_NONE;
        owner_cpu_d = (state_q == ST_CPU);
        if (bus_active_s) begin
            if (hit_rom(src_addr_s)) begin
                rsel_d = SEL_ROM;
            end else if (hit_ram(src_addr_s) || hit_io(src_addr_s)) begin
                rsel_d = SEL_RIOT;
            end else begin
                rsel_d = SEL_UNMAP;
            end
        end else begin
            rsel_d = SEL_NONE;
        end
    end

    // Read-data return mux for the access issued last cycle.
    always_comb begin
        rd_mux_s = 8'hFF;
        case (rsel_q)
            SEL_ROM:   rd_mux_s = bus.rom_rdata;
            SEL_RIOT:  rd_mux_s = bus.riot_rdata;
            SEL_UNMAP: rd_mux_s = 8'hFF;
            default:   rd_mux_s = 8'hFF;
        endcase
    end

    // Hold registers keep CPU and debug data stable between their own accesses.
    always_comb begin
        hold_d      = hold_q;
        dbg_rdata_d = dbg_rdata_q;
        if (owner_cpu_q && (rsel_q != SEL_NONE)) begin
            hold_d = rd_mux_s;
        end else begin
            hold_d = hold_q;
        end
        if (state_q == ST_ACK) begin
            dbg_rdata_d = rd_mux_s;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    assign bus.mem_addr    = src_addr_s;
    assign bus.mem_wdata   = src_wdata_s;
    assign bus.mem_we      = src_we_s && bus_active_s && reset_n && !hit_rom(src_addr_s);
    assign bus.rom_cs      = rom_cs_s;
    assign bus.riot_ram_cs = ram_cs_s;
    assign bus.riot_io_cs  = io_cs_s;

    assign bus.cpu_rdy   = (state_q == ST_CPU);
    assign bus.cpu_di    = (owner_cpu_q && (rsel_q != SEL_NONE)) ? rd_mux_s : hold_q;
    assign bus.dbg_ack   = (state_q == ST_ACK);
    assign bus.dbg_rdata = (state_q == ST_ACK) ? rd_mux_s : dbg_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: CPU traffic, debug peek/poke, halt, back-to-back requests and reset abort.
module tb_bus_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   passes;

    bus_arbiter_if bif();

    bus_arbiter #(
        .ROM_BASE(4'hF),
        .RAM_BASE(9'h001),
        .IO_BASE (11'h014)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bif.cpu_ab = 16'hF000; bif.cpu_we = 1'b1; bif.cpu_do = 8'h12;
        tick(); tick();
        checks++; if (bif.rom_cs !== 1'b0) $display("FAIL rst_rom_cs got %0b want 0", bif.rom_cs); else passes++;
        checks++; if (bif.mem_we !== 1'b0) $display("FAIL rst_mem_we got %0b want 0", bif.mem_we); else passes++;
        checks++; if (bif.cpu_rdy !== 1'b1) $display("FAIL rst_rdy got %0b want 1", bif.cpu_rdy); else passes++;
        reset_n = 1'b1; bif.cpu_we = 1'b0;
        #1;
        checks++; if (bif.dbg_ack !== 1'b0) $display("FAIL rst_ack got %0b want 0", bif.dbg_ack); else passes++;
        checks++; if (bif.dbg_rdata !== 8'h00) $display("FAIL rst_dbg_rdata got %h want 00", bif.dbg_rdata); else passes++;
        checks++; if (bif.cpu_di !== 8'h00) $display("FAIL rst_cpu_di got %h want 00", bif.cpu_di); else passes++;
    endtask

    task automatic test_cpu_read();
        bif.cpu_ab = 16'hF000; bif.cpu_we = 1'b0; bif.rom_rdata = 8'h00;
        #1;
        checks++; if (bif.rom_cs !== 1'b1) $display("FAIL cpu_rd_rom_cs got %0b want 1", bif.rom_cs); else passes++;
        checks++; if (bif.mem_addr !== 16'hF000) $display("FAIL cpu_rd_addr got %h want F000", bif.mem_addr); else passes++;
        tick();
        bif.rom_rdata = 8'hA9;
        #1;
        checks++; if (bif.cpu_di !== 8'hA9) $display("FAIL cpu_rd_di got %h want A9", bif.cpu_di); else passes++;
        checks++; if (bif.cpu_rdy !== 1'b1) $display("FAIL cpu_rd_rdy got %0b want 1", bif.cpu_rdy); else passes++;
    endtask

    task automatic test_dbg_write();
        bif.riot_rdata = 8'h77;
        bif.dbg_req = 1'b1; bif.dbg_we = 1'b1; bif.dbg_addr = 16'h0085; bif.dbg_wdata = 8'h5A;
        tick();
        checks++; if (bif.cpu_rdy !== 1'b0) $display("FAIL dw_n1_rdy got %0b want 0", bif.cpu_rdy); else passes++;
        checks++; if (bif.mem_addr !== 16'h0085) $display("FAIL dw_n1_addr got %h want 0085", bif.mem_addr); else passes++;
        checks++; if (bif.mem_we !== 1'b1) $display("FAIL dw_n1_we got %0b want 1", bif.mem_we); else passes++;
        checks++; if (bif.riot_ram_cs !== 1'b1) $display("FAIL dw_n1_ramcs got %0b want 1", bif.riot_ram_cs); else passes++;
        checks++; if (bif.mem_wdata !== 8'h5A) $display("FAIL dw_n1_wdata got %h want 5A", bif.mem_wdata); else passes++;
        checks++; if (bif.cpu_di !== 8'hA9) $display("FAIL dw_n1_di got %h want A9", bif.cpu_di); else passes++;
        tick();
        checks++; if (bif.dbg_ack !== 1'b1) $display("FAIL dw_n2_ack got %0b want 1", bif.dbg_ack); else passes++;
        checks++; if (bif.mem_we !== 1'b0) $display("FAIL dw_n2_we got %0b want 0", bif.mem_we); else passes++;
        checks++; if (bif.cpu_di !== 8'hA9) $display("FAIL dw_n2_di got %h want A9", bif.cpu_di); else passes++;
        checks++; if (bif.dbg_rdata !== 8'h77) $display("FAIL dw_n2_rdata got %h want 77", bif.dbg_rdata); else passes++;
        tick();
        bif.dbg_req = 1'b0;
        #1;
        checks++; if (bif.cpu_rdy !== 1'b1) $display("FAIL dw_n3_rdy got %0b want 1", bif.cpu_rdy); else passes++;
        checks++; if (bif.dbg_ack !== 1'b0) $display("FAIL dw_n3_ack got %0b want 0", bif.dbg_ack); else passes++;
    endtask

    task automatic test_halt_read();
        bif.dbg_halt = 1'b1;
        tick();
        bif.cpu_ab = 16'h0085; bif.cpu_we = 1'b1;
        #1;
        checks++; if (bif.cpu_rdy !== 1'b0) $display("FAIL hr_halt_rdy got %0b want 0", bif.cpu_rdy); else passes++;
        checks++; if (bif.mem_we !== 1'b0) $display("FAIL hr_halt_we got %0b want 0", bif.mem_we); else passes++;
        checks++; if (bif.riot_ram_cs !== 1'b0) $display("FAIL hr_halt_cs got %0b want 0", bif.riot_ram_cs); else passes++;
        checks++; if (bif.mem_addr !== 16'h0085) $display("FAIL hr_halt_addr got %h want 0085", bif.mem_addr); else passes++;
        bif.dbg_req = 1'b1; bif.dbg_we = 1'b0; bif.dbg_addr = 16'h0282; bif.riot_rdata = 8'h3C;
        tick();
        checks++; if (bif.riot_io_cs !== 1'b1) $display("FAIL hr_dbg_iocs got %0b want 1", bif.riot_io_cs); else passes++;
        checks++; if (bif.mem_we !== 1'b0) $display("FAIL hr_dbg_we got %0b want 0", bif.mem_we); else passes++;
        tick();
        checks++; if (bif.dbg_ack !== 1'b1) $display("FAIL hr_ack got %0b want 1", bif.dbg_ack); else passes++;
        checks++; if (bif.dbg_rdata !== 8'h3C) $display("FAIL hr_rdata got %h want 3C", bif.dbg_rdata); else passes++;
        checks++; if (bif.cpu_rdy !== 1'b0) $display("FAIL hr_ack_rdy got %0b want 0", bif.cpu_rdy); else passes++;
        tick();
        bif.dbg_req = 1'b0; bif.riot_rdata = 8'h11;
        #1;
        checks++; if (bif.cpu_rdy !== 1'b0) $display("FAIL hr_back_rdy got %0b want 0", bif.cpu_rdy); else passes++;
        checks++; if (bif.dbg_ack !== 1'b0) $display("FAIL hr_back_ack got %0b want 0", bif.dbg_ack); else passes++;
        checks++; if (bif.dbg_rdata !== 8'h3C) $display("FAIL hr_hold_rdata got %h want 3C", bif.dbg_rdata); else passes++;
        bif.dbg_halt = 1'b0;
        tick();
        checks++; if (bif.cpu_rdy !== 1'b1) $display("FAIL hr_release_rdy got %0b want 1", bif.cpu_rdy); else passes++;
        checks++; if (bif.mem_we !== 1'b1) $display("FAIL hr_cpu_we got %0b want 1", bif.mem_we); else passes++;
        bif.cpu_we = 1'b0;
    endtask

    task automatic test_rom_write_unmapped();
        bif.cpu_ab = 16'hF010; bif.cpu_we = 1'b1; bif.cpu_do = 8'hEE;
        #1;
        checks++; if (bif.rom_cs !== 1'b1) $display("FAIL romwr_cs got %0b want 1", bif.rom_cs); else passes++;
        checks++; if (bif.mem_we !== 1'b0) $display("FAIL romwr_we got %0b want 0", bif.mem_we); else passes++;
        bif.cpu_we = 1'b0;
        bif.dbg_req = 1'b1; bif.dbg_we = 1'b0; bif.dbg_addr = 16'h4000;
        tick();
        checks++; if ({bif.rom_cs, bif.riot_ram_cs, bif.riot_io_cs} !== 3'b000)
            $display("FAIL unmap_cs got %b want 000", {bif.rom_cs, bif.riot_ram_cs, bif.riot_io_cs}); else passes++;
        checks++; if (bif.mem_addr !== 16'h4000) $display("FAIL unmap_addr got %h want 4000", bif.mem_addr); else passes++;
        tick();
        checks++; if (bif.dbg_ack !== 1'b1) $display("FAIL unmap_ack got %0b want 1", bif.dbg_ack); else passes++;
        checks++; if (bif.dbg_rdata !== 8'hFF) $display("FAIL unmap_rdata got %h want FF", bif.dbg_rdata); else passes++;
        tick();
        bif.dbg_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        logic exp_ack;
        bif.cpu_ab = 16'hF000;
        bif.dbg_req = 1'b1; bif.dbg_we = 1'b0; bif.dbg_addr = 16'h0090; bif.riot_rdata = 8'h11;
        for (int i = 0; i < 9; i++) begin
            exp_rdy = ((i % 3) == 0);
            exp_ack = ((i % 3) == 2);
            #1;
            checks++; if (bif.cpu_rdy !== exp_rdy) $display("FAIL b2b_rdy[%0d] got %0b want %0b", i, bif.cpu_rdy, exp_rdy); else passes++;
            checks++; if (bif.dbg_ack !== exp_ack) $display("FAIL b2b_ack[%0d] got %0b want %0b", i, bif.dbg_ack, exp_ack); else passes++;
            tick();
        end
        bif.dbg_req = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        #1;
        checks++; if (bif.dbg_rdata !== 8'h11) $display("FAIL rmw_pre_rdata got %h want 11", bif.dbg_rdata); else passes++;
        bif.dbg_req = 1'b1; bif.dbg_we = 1'b1; bif.dbg_addr = 16'h0085; bif.dbg_wdata = 8'h5A;
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (bif.mem_we !== 1'b0) $display("FAIL rmw_we got %0b want 0", bif.mem_we); else passes++;
        checks++; if (bif.riot_ram_cs !== 1'b0) $display("FAIL rmw_cs got %0b want 0", bif.riot_ram_cs); else passes++;
        checks++; if (bif.mem_addr !== 16'h0085) $display("FAIL rmw_addr got %h want 0085", bif.mem_addr); else passes++;
        tick();
        reset_n = 1'b1; bif.dbg_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bif.dbg_ack !== 1'b0) $display("FAIL rmw_ack[%0d] got %0b want 0", i, bif.dbg_ack); else passes++;
            checks++; if (bif.cpu_rdy !== 1'b1) $display("FAIL rmw_rdy[%0d] got %0b want 1", i, bif.cpu_rdy); else passes++;
            checks++; if (bif.dbg_rdata !== 8'h00) $display("FAIL rmw_rdata[%0d] got %h want 00", i, bif.dbg_rdata); else passes++;
            tick();
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset_n = 1'b0;
        bif.cpu_ab = 16'h0000; bif.cpu_do = 8'h00; bif.cpu_we = 1'b0;
        bif.dbg_req = 1'b0; bif.dbg_we = 1'b0; bif.dbg_addr = 16'h0000;
        bif.dbg_wdata = 8'h00; bif.dbg_halt = 1'b0;
        bif.rom_rdata = 8'h00; bif.riot_rdata = 8'h00;

        test_reset();
        test_cpu_read();
        tick();
        test_dbg_write();
        tick();
        test_halt_read();
        tick();
        test_rom_write_unmapped();
        tick();
        test_back_to_back();
        tick();
        test_reset_mid_write();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Owns the 65C02 system bus and shares the RIOT and ROM between two requesters: the CPU core and a debug/loader port.
- The debug/loader port is driven by the UART monitor and is used for memory peek/poke and for halting the CPU.
- Performs address decode to chip selects, muxes read data back to the winning requester, and stalls the CPU through RDY while the debug side owns the bus.
- Sits in fpga_6502 between cpu_65c02 and the RIOT/ROM instances.

Parameters:
ROM_BASE, 4'hF, address bits [15:12] that select ROM (4 KB window).
RAM_BASE, 9'h001, address bits [15:7] that select RIOT RAM (0x0080-0x00FF).
IO_BASE, 11'h014, address bits [15:5] that select RIOT I/O/timer (0x0280-0x029F).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  synchronous active-low reset.
cpu_ab  in  16  CPU address.
cpu_do  in  8  CPU write data.
cpu_we  in  1  CPU write enable.
cpu_di  out  8  read data to CPU.
cpu_rdy  out  1  CPU RDY; 0 stalls the core.
dbg_req  in  1  debug access request, level, held until dbg_ack.
dbg_we  in  1  debug write (1) / read (0).
dbg_addr  in  16  debug address.
dbg_wdata  in  8  debug write data.
dbg_halt  in  1  hold CPU stalled while high.
dbg_ack  out  1  one-cycle completion pulse.
dbg_rdata  out  8  debug read data, valid with dbg_ack, held until next ack.
mem_addr  out  16  shared bus address.
mem_wdata  out  8  shared bus write data.
mem_we  out  1  shared bus write strobe.
rom_cs  out  1  ROM select.
riot_ram_cs  out  1  RIOT RAM select.
riot_io_cs  out  1  RIOT I/O select.
rom_rdata  in  8  ROM read data, 1-cycle synchronous latency.
riot_rdata  in  8  RIOT read data, 1-cycle synchronous latency.

Behaviour:
- States:
  - CPU: bus owned by the CPU.
  - DBG: bus owned by the debug port.
  - ACK: debug read data returned.
  - HALT: bus idle, CPU stalled.
- Outputs are derived from the state register.
- cpu_rdy = (state==CPU).
- Reset (reset_n low at edge):
  - state is CPU, so cpu_rdy=1.
  - dbg_ack=0, dbg_rdata=8'h00, cpu_di hold register=8'h00, read-select register=none.
  - In any cycle with reset_n low, mem_we and all chip selects are forced to 0, so a debug write in flight is abandoned, never half-issued.
- Bus source:
  - CPU state: mem_* driven by cpu_ab/cpu_do/cpu_we.
  - DBG state: mem_* driven by dbg_addr/dbg_wdata/dbg_we.
  - ACK and HALT: mem_we=0, all chip selects 0, mem_addr = cpu_ab.
- Decode (combinational on mem_addr, at most one select high):
  - rom_cs when addr[15:12]==ROM_BASE.
  - riot_ram_cs when addr[15:7]==RAM_BASE.
  - riot_io_cs when addr[15:5]==IO_BASE.
  - Unmapped: no select, read data 8'hFF.
- mem_we is gated low when rom_cs is high; ROM writes are dropped silently.
- Read return:
  - Source select (rom/riot/unmapped) and owner are registered in the access cycle.
  - The next cycle muxes the selected read data (rom_rdata, riot_rdata, or 8'hFF).
  - A CPU-owned access drives that muxed value onto cpu_di and captures it into the hold register.
  - Otherwise cpu_di shows the hold register, so the CPU sees stable data while stalled.
- Transitions:
  - CPU: dbg_req goes to DBG; else dbg_halt goes to HALT; else stay in CPU. The CPU access issued in the transition cycle completes normally (rdy was 1).
  - DBG goes to ACK unconditionally. The access takes one bus cycle.
  - ACK: dbg_ack=1 and dbg_rdata is loaded with the muxed read data (for writes, the data read at that address). Next state is HALT if dbg_halt, else CPU. dbg_req is ignored in ACK.
  - HALT: dbg_req goes to DBG; else !dbg_halt goes to CPU.
- Handshake: the requester holds dbg_req stable with addr/data until it samples dbg_ack=1, then drops dbg_req on that same edge.
- Fairness: without dbg_halt, ACK always returns to CPU for at least one cycle. The worst case is one CPU cycle per three cycles.
- Simultaneous dbg_req and dbg_halt in CPU or HALT: the request wins; halt is re-evaluated in ACK.

Test Plan:
- CPU only, debug idle: CPU reads 0xF000 with rom_rdata=8'hA9 -> rom_cs=1 same cycle; cpu_di=8'hA9 next cycle; cpu_rdy stays 1.
- Debug write 8'h5A to 0x0085 while CPU runs:
  - cycle N+1: cpu_rdy=0, mem_addr=0x0085, mem_we=1, riot_ram_cs=1.
  - cycle N+2: dbg_ack=1.
  - cycle N+3: cpu_rdy=1.
  - cpu_di unchanged throughout the stall.
- dbg_halt=1, then debug read of 0x0282 with riot_rdata=8'h3C -> cpu_rdy stays 0; dbg_ack with dbg_rdata=8'h3C; state returns to HALT; releasing halt -> cpu_rdy=1 next cycle.
- CPU write to 0xF010 -> mem_we=0. Debug read of unmapped 0x4000 -> no chip select, dbg_rdata=8'hFF.
- Back-to-back debug requests with no halt -> cpu_rdy pattern 0,0,1 repeating; every third cycle is a CPU access.
- reset_n low during the DBG cycle of a write -> mem_we=0 that cycle; dbg_ack never pulses; after release cpu_rdy=1 and dbg_rdata=8'h00.
